// File: rtl/mmio_uart_tx_pkg.sv
// Shared field positions and FSM state encoding for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    localparam int CMD_DATA_LSB    = 0;
    localparam int CMD_DATA_MSB    = 7;
    localparam int CMD_TOGGLE_BIT  = 8;
    localparam int CMD_OVF_CLR_BIT = 9;

    localparam int STS_DONE_BIT    = 0;
    localparam int STS_FULL_BIT    = 1;
    localparam int STS_OVF_BIT     = 2;
    localparam int STS_COUNT_LSB   = 3;
    localparam int STS_COUNT_MSB   = 7;
    localparam int STS_ACK_BIT     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Circular byte buffer between the command register and the serializer.
module mmio_uart_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wrData,
    output logic [7:0]    rdData,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    assign rdData = mem[rdPtr];
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// 8N1 UART transmitter driven by a toggle-handshake command word, with a byte FIFO and status word.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mmioOutWord,
    output logic [31:0] mmioInWord,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;

    txState_e      state;
    logic [BW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          prevToggle;
    logic [31:0]   statusReg;
    logic [31:0]   statusNext;

    logic          writeReq;
    logic          bitEnd;
    logic          push;
    logic          pop;
    logic          dropWrite;
    logic          overflowNext;
    logic          idleNext;
    logic [CW-1:0] countNext;

    logic [7:0]    fifoData;
    logic [CW-1:0] fifoCount;
    logic          fifoFull;
    logic          fifoEmpty;

    logic          unusedCmdBits;

    assign unusedCmdBits = ^mmioOutWord[31:10];

    assign writeReq  = mmioOutWord[CMD_TOGGLE_BIT] ^ prevToggle;
    assign bitEnd    = (baudCnt == BW'(CLOCKS_PER_BIT - 1));
    assign pop       = !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitEnd));
    // A full FIFO still takes a write when a byte leaves on the same edge.
    assign push      = writeReq && (!fifoFull || pop);
    assign dropWrite = writeReq && fifoFull && !pop;

    assign overflowNext = dropWrite || (statusReg[STS_OVF_BIT] && !mmioOutWord[CMD_OVF_CLR_BIT]);
    assign countNext    = fifoCount + CW'(push) - CW'(pop);
    assign idleNext     = fifoEmpty && ((state == IDLE) || ((state == STOP) && bitEnd));

    mmio_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wrData (mmioOutWord[CMD_DATA_MSB:CMD_DATA_LSB]),
        .rdData (fifoData),
        .count  (fifoCount),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Status is built from next-state values so the registered word lines up with the edge that caused it.
    always_comb begin
        statusNext = '0;
        statusNext[STS_DONE_BIT]                  = idleNext && (countNext == '0);
        statusNext[STS_FULL_BIT]                  = (countNext == CW'(FIFO_DEPTH));
        statusNext[STS_OVF_BIT]                   = overflowNext;
        statusNext[STS_COUNT_MSB:STS_COUNT_LSB]   = 5'(countNext);
        statusNext[STS_ACK_BIT]                   = mmioOutWord[CMD_TOGGLE_BIT];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            statusReg               <= '0;
            statusReg[STS_DONE_BIT] <= 1'b1;
            statusReg[STS_ACK_BIT]  <= mmioOutWord[CMD_TOGGLE_BIT];
        end else begin
            statusReg <= statusNext;
        end
    end

    assign mmioInWord = statusReg;

    // prevToggle follows the command even in reset so release never looks like a write.
    always_ff @(posedge clock) begin
        prevToggle <= mmioOutWord[CMD_TOGGLE_BIT];
        if (reset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    baudCnt <= '0;
                    if (pop) begin
                        state    <= START;
                        txd      <= 1'b0;
                        shiftReg <= fifoData;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        state   <= DATA;
                        txd     <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= shiftReg >> 1;
                            txd      <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        if (pop) begin
                            state    <= START;
                            txd      <= 1'b0;
                            shiftReg <= fifoData;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
